// File: rtl/cursor_mode_ctrl.sv
// Cursor overlay sequencer: frame-latched clamped position plus arrow/scope mode,
// aim delay, single-shot fire pulse and reload cooldown, all on the pixel clock.
module cursor_mode_ctrl #(
  parameter int GAME_W        = 768,
  parameter int X_MAX         = 1024,
  parameter int Y_MAX         = 768,
  parameter int AIM_FRAMES    = 4,
  parameter int RELOAD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        left,
  input  logic        right,
  input  logic        vblnk,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        select_mode,
  output logic        fire,
  output logic        reload_busy,
  output logic [7:0]  shot_count
);

  localparam int AW = $clog2(AIM_FRAMES) + 1;
  localparam int RW = $clog2(RELOAD_FRAMES) + 1;

  localparam logic [11:0]   X_LIM       = 12'(X_MAX - 1);
  localparam logic [11:0]   Y_LIM       = 12'(Y_MAX - 1);
  localparam logic [11:0]   GAME_LIM    = 12'(GAME_W);
  localparam logic [AW-1:0] AIM_LAST    = AW'(AIM_FRAMES - 1);
  localparam logic [RW-1:0] RELOAD_INIT = RW'(RELOAD_FRAMES);
  localparam logic [RW-1:0] RELOAD_LAST = RW'(1);

  typedef enum logic [2:0] {
    MOUSE  = 3'd0,
    AIM    = 3'd1,
    SCOPE  = 3'd2,
    FIRE   = 3'd3,
    RELOAD = 3'd4
  } state_t;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] aim_cnt_q, aim_cnt_d;
  logic [RW-1:0] reload_cnt_q, reload_cnt_d;
  logic [7:0]    shot_cnt_q, shot_cnt_d;
  logic [11:0]   xpos_q, xpos_d;
  logic [11:0]   ypos_q, ypos_d;
  logic          select_q, select_d;
  logic          fire_q, fire_d;
  logic          busy_q, busy_d;
  logic          vblnk_prev_q, left_prev_q;

  logic frame_tick, left_rise, in_area, stay;

  always_comb begin
    frame_tick   = vblnk & ~vblnk_prev_q;
    left_rise    = left & ~left_prev_q;
    in_area      = (xpos_in < GAME_LIM);
    stay         = right & in_area;

    state_d      = state_q;
    aim_cnt_d    = aim_cnt_q;
    reload_cnt_d = reload_cnt_q;
    shot_cnt_d   = shot_cnt_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;

    if (frame_tick) begin
      xpos_d = clamp12(xpos_in, X_LIM);
      ypos_d = clamp12(ypos_in, Y_LIM);
    end

    case (state_q)
      MOUSE: begin
        if (stay) begin
          state_d   = AIM;
          aim_cnt_d = '0;
        end
      end
      AIM: begin
        if (!stay) begin
          state_d = MOUSE;
        end else if (frame_tick) begin
          if (aim_cnt_q == AIM_LAST) state_d = SCOPE;
          else                       aim_cnt_d = aim_cnt_q + 1'b1;
        end
      end
      SCOPE: begin
        // Losing the aim wins over a coincident click: no shot in that case.
        if (!stay) begin
          state_d = MOUSE;
        end else if (left_rise) begin
          state_d    = FIRE;
          shot_cnt_d = shot_cnt_q + 1'b1;
        end
      end
      FIRE: begin
        state_d      = RELOAD;
        reload_cnt_d = RELOAD_INIT;
      end
      RELOAD: begin
        if (frame_tick) begin
          reload_cnt_d = reload_cnt_q - 1'b1;
          if (reload_cnt_q == RELOAD_LAST) state_d = stay ? SCOPE : MOUSE;
        end
      end
      default: state_d = MOUSE;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    select_d = (state_d == SCOPE) || (state_d == FIRE) || ((state_d == RELOAD) && stay);
    fire_d   = (state_d == FIRE);
    busy_d   = (state_d == RELOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MOUSE;
      aim_cnt_q    <= '0;
      reload_cnt_q <= '0;
      shot_cnt_q   <= '0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      select_q     <= 1'b0;
      fire_q       <= 1'b0;
      busy_q       <= 1'b0;
      vblnk_prev_q <= 1'b0;
      left_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      aim_cnt_q    <= aim_cnt_d;
      reload_cnt_q <= reload_cnt_d;
      shot_cnt_q   <= shot_cnt_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      select_q     <= select_d;
      fire_q       <= fire_d;
      busy_q       <= busy_d;
      vblnk_prev_q <= vblnk;
      left_prev_q  <= left;
    end
  end

  assign xpos_out    = xpos_q;
  assign ypos_out    = ypos_q;
  assign select_mode = select_q;
  assign fire        = fire_q;
  assign reload_busy = busy_q;
  assign shot_count  = shot_cnt_q;

endmodule

// File: tb/tb_cursor_mode_ctrl.sv
// Scoreboard bench for cursor_mode_ctrl: stimulus queues expected snapshots and
// expected shots; one negedge monitor pops and compares them against the DUT.
module tb_cursor_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos_in, ypos_in;
  logic        left, right, vblnk;
  logic [11:0] xpos_out, ypos_out;
  logic        select_mode, fire, reload_busy;
  logic [7:0]  shot_count;

  cursor_mode_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .xpos_in     (xpos_in),
    .ypos_in     (ypos_in),
    .left        (left),
    .right       (right),
    .vblnk       (vblnk),
    .xpos_out    (xpos_out),
    .ypos_out    (ypos_out),
    .select_mode (select_mode),
    .fire        (fire),
    .reload_busy (reload_busy),
    .shot_count  (shot_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [11:0] x;
    logic [11:0] y;
    logic        sel;
    logic        busy;
    logic [7:0]  sh;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fire_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       done  = 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    vblnk = 1'b1;
    step(1);
    vblnk = 1'b0;
    step(1);
  endtask

  task automatic chk(input string nm, input logic [11:0] x, input logic [11:0] y,
                     input logic sel, input logic busy, input logic [7:0] sh);
    exp_t e;
    e.nm = nm; e.x = x; e.y = y; e.sel = sel; e.busy = busy; e.sh = sh;
    exp_q.push_back(e);
  endtask

  // Monitor: fire pulses are matched against queued shots, snapshots against the DUT state.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] es;
    if (fire === 1'b1) begin
      n_cmp++;
      if (fire_q.size() == 0) begin
        n_bad++;
        $display("FAIL fire_unexpected: fire=1 shot_count=%0d, required no shot", shot_count);
      end else begin
        es = fire_q.pop_front();
        if (shot_count !== es) begin
          n_bad++;
          $display("FAIL fire_count: shot_count=%0d required %0d", shot_count, es);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({xpos_out, ypos_out, select_mode, reload_busy, shot_count} !==
          {e.x, e.y, e.sel, e.busy, e.sh}) begin
        n_bad++;
        $display("FAIL %s: x=%0d y=%0d sel=%0b busy=%0b shots=%0d required x=%0d y=%0d sel=%0b busy=%0b shots=%0d",
                 e.nm, xpos_out, ypos_out, select_mode, reload_busy, shot_count,
                 e.x, e.y, e.sel, e.busy, e.sh);
      end
    end
    if (done) begin
      n_cmp++;
      if (fire_q.size() != 0) begin
        n_bad++;
        $display("FAIL fire_missing: %0d shots never seen, required 0", fire_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; xpos_in = '0; ypos_in = '0; left = 1'b0; right = 1'b0; vblnk = 1'b0;
    step(3);
    chk("reset", 0, 0, 0, 0, 0);

    // Position latch and clamping
    rst = 1'b0; xpos_in = 12'd2000; ypos_in = 12'd900;
    step(2);
    chk("pos_before_tick", 0, 0, 0, 0, 0);
    vblnk = 1'b1;
    step(1);
    chk("pos_clamp", 1023, 767, 0, 0, 0);
    xpos_in = 12'd50; ypos_in = 12'd60;
    step(3);
    chk("vblnk_held_one_tick", 1023, 767, 0, 0, 0);
    vblnk = 1'b0;
    step(1);
    tick();
    chk("pos_pass", 50, 60, 0, 0, 0);

    // Aim delay
    xpos_in = 12'd100; ypos_in = 12'd200; right = 1'b1;
    step(1);
    repeat (3) tick();
    chk("aim_3_ticks", 100, 200, 0, 0, 0);
    tick();
    chk("aim_4th_scope", 100, 200, 1, 0, 0);

    // Shot and cooldown
    fire_q.push_back(8'd1);
    left = 1'b1;
    step(1);
    chk("fire_shot", 100, 200, 1, 0, 1);
    left = 1'b0;
    step(1);
    chk("reload_start", 100, 200, 1, 1, 1);
    for (int i = 0; i < 59; i++) begin
      left = 1'b1; step(1); left = 1'b0; step(1);
      tick();
    end
    chk("reload_59", 100, 200, 1, 1, 1);
    tick();
    chk("reload_done", 100, 200, 1, 0, 1);

    // Leaving the play area, then re-aiming
    xpos_in = 12'd800;
    step(1);
    chk("scope_exit_x", 100, 200, 0, 0, 1);
    xpos_in = 12'd700;
    step(1);
    repeat (3) tick();
    chk("reaim_3", 700, 200, 0, 0, 1);
    tick();
    chk("reaim_4", 700, 200, 1, 0, 1);

    // Releasing right after 3 ticks aborts the aim
    right = 1'b0;
    step(1);
    chk("release_mouse", 700, 200, 0, 0, 1);
    right = 1'b1;
    step(1);
    repeat (3) tick();
    right = 1'b0;
    step(1);
    tick();
    chk("aim_abort", 700, 200, 0, 0, 1);
    right = 1'b1;
    step(1);
    repeat (3) tick();
    chk("aim_restart_3", 700, 200, 0, 0, 1);
    tick();
    chk("aim_restart_4", 700, 200, 1, 0, 1);

    // Play-area edge
    right = 1'b0;
    step(1);
    xpos_in = 12'd768; right = 1'b1;
    step(1);
    repeat (4) tick();
    chk("x768_no_aim", 768, 200, 0, 0, 1);
    xpos_in = 12'd767;
    step(1);
    repeat (4) tick();
    chk("x767_scope", 767, 200, 1, 0, 1);

    // Left held while entering the scope must not fire
    right = 1'b0;
    step(1);
    left = 1'b1;
    step(2);
    right = 1'b1;
    step(1);
    repeat (4) tick();
    step(2);
    chk("held_left_nofire", 767, 200, 1, 0, 1);
    left = 1'b0;
    step(1);
    fire_q.push_back(8'd2);
    left = 1'b1;
    step(1);
    chk("refire", 767, 200, 1, 0, 2);
    left = 1'b0;
    step(1);
    chk("refire_reload", 767, 200, 1, 1, 2);

    // Reset in the middle of the cooldown
    repeat (30) tick();
    rst = 1'b1;
    step(1);
    chk("rst_mid_reload", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // 256 shots wrap the counter
    step(1);
    repeat (4) tick();
    chk("wrap_scope", 767, 200, 1, 0, 0);
    for (int s = 1; s <= 256; s++) begin
      fire_q.push_back(8'(s));
      left = 1'b1; step(1); left = 1'b0; step(1);
      repeat (60) tick();
      if (s == 255) chk("shots_255", 767, 200, 1, 0, 255);
    end
    chk("shots_wrap", 767, 200, 1, 0, 0);

    step(2);
    done = 1'b1;
    step(20);
    $display("FAIL monitor_stalled: summary not reached, required summary");
    $fatal(1);
  end

endmodule
